// File: rtl/data_skew_buf.sv
// rtl/data_skew_buf.sv - diagonal skew buffer feeding the row inputs of a 2D array
//
// Lane k is a chain of k+1 word registers, so a beat accepted on one edge
// leaves lane 0 one edge later and lane 7 eight edges later. The array is
// therefore fed along a diagonal.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, in_last, in_ready beat handshake (in_ready = ~stall)
//   data_i_0..data_i_7          lane words in (DW bits each)
//   stall                       freeze all internal state
//   data_o_0..data_o_7          skewed lane words out (tail of each chain)
//   valid_o[7:0]                per-lane valid for data_o_k
//   done_o                      last beat of a burst consumed from lane 7
//   busy_o                      any valid beat held in the block
module data_skew_buf #(
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [DW-1:0] data_i_0,
  input  logic [DW-1:0] data_i_1,
  input  logic [DW-1:0] data_i_2,
  input  logic [DW-1:0] data_i_3,
  input  logic [DW-1:0] data_i_4,
  input  logic [DW-1:0] data_i_5,
  input  logic [DW-1:0] data_i_6,
  input  logic [DW-1:0] data_i_7,
  input  logic          stall,
  output logic [DW-1:0] data_o_0,
  output logic [DW-1:0] data_o_1,
  output logic [DW-1:0] data_o_2,
  output logic [DW-1:0] data_o_3,
  output logic [DW-1:0] data_o_4,
  output logic [DW-1:0] data_o_5,
  output logic [DW-1:0] data_o_6,
  output logic [DW-1:0] data_o_7,
  output logic [7:0]    valid_o,
  output logic          done_o,
  output logic          busy_o
);

  localparam int LANES = 8;

  logic [DW-1:0]    din  [LANES];
  logic [DW-1:0]    dout [LANES];
  logic [LANES-1:0] lane_busy;
  logic [LANES-1:0] last_sr;
  logic             accept;

  assign din[0] = data_i_0;
  assign din[1] = data_i_1;
  assign din[2] = data_i_2;
  assign din[3] = data_i_3;
  assign din[4] = data_i_4;
  assign din[5] = data_i_5;
  assign din[6] = data_i_6;
  assign din[7] = data_i_7;

  assign data_o_0 = dout[0];
  assign data_o_1 = dout[1];
  assign data_o_2 = dout[2];
  assign data_o_3 = dout[3];
  assign data_o_4 = dout[4];
  assign data_o_5 = dout[5];
  assign data_o_6 = dout[6];
  assign data_o_7 = dout[7];

  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int DEPTH = k + 1;

    logic [DW-1:0]    dat [DEPTH];
    logic [DEPTH-1:0] vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          dat[i] <= '0;
        end
        vld <= '0;
      end else if (!stall) begin
        // Bubbles carry zero data so the array accumulates nothing on them.
        dat[0] <= accept ? din[k] : '0;
        vld[0] <= accept;
        for (int i = 1; i < DEPTH; i++) begin
          dat[i] <= dat[i-1];
          vld[i] <= vld[i-1];
        end
      end
    end

    assign dout[k]      = dat[DEPTH-1];
    assign valid_o[k]   = vld[DEPTH-1];
    assign lane_busy[k] = |vld;
  end

  // The last tag rides alongside lane 7 only; it is what drives done_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sr <= '0;
    end else if (!stall) begin
      last_sr <= {last_sr[LANES-2:0], accept & in_last};
    end
  end

  // The tail beat is consumed only on a non-stalled cycle.
  assign done_o = valid_o[LANES-1] & last_sr[LANES-1] & ~stall;
  assign busy_o = |lane_busy;

endmodule
